// File: rtl/alu_share_arb.sv
// Round-robin sharing of one combinational ALU among NUM_REQ valid/ready requesters.
// Issue register feeds the ALU, response register captures it: latency 2, a held response freezes both.
module alu_share_arb #(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic [32*NUM_REQ-1:0] req_a,
   input  logic [32*NUM_REQ-1:0] req_b,
   input  logic [5*NUM_REQ-1:0]  req_op,
   input  logic [32*NUM_REQ-1:0] req_pc,
   output logic [31:0]           alu_A,
   output logic [31:0]           alu_B,
   output logic [31:0]           alu_PC,
   output logic [4:0]            alu_op,
   input  logic [31:0]           alu_C,
   input  logic                  alu_zero,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [ID_W-1:0]       resp_id,
   output logic [31:0]           resp_c,
   output logic                  resp_zero
);

   logic [31:0] a_arr  [NUM_REQ];
   logic [31:0] b_arr  [NUM_REQ];
   logic [31:0] pc_arr [NUM_REQ];
   logic [4:0]  op_arr [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign a_arr[i]  = req_a[32*i +: 32];
      assign b_arr[i]  = req_b[32*i +: 32];
      assign pc_arr[i] = req_pc[32*i +: 32];
      assign op_arr[i] = req_op[5*i +: 5];
   end

   logic            s1_valid_q, s1_valid_d;
   logic [ID_W-1:0] s1_id_q, s1_id_d;
   logic [31:0]     s1_a_q, s1_a_d;
   logic [31:0]     s1_b_q, s1_b_d;
   logic [31:0]     s1_pc_q, s1_pc_d;
   logic [4:0]      s1_op_q, s1_op_d;
   logic            resp_valid_q, resp_valid_d;
   logic [ID_W-1:0] resp_id_q, resp_id_d;
   logic [31:0]     resp_c_q, resp_c_d;
   logic            resp_zero_q, resp_zero_d;
   logic [ID_W-1:0] ptr_q, ptr_d;

   logic            stall, s2_adv, s1_free, accept;
   logic            gnt_found;
   logic [ID_W-1:0] gnt_idx, cand;

   assign stall   = resp_valid_q & ~resp_ready;
   assign s2_adv  = s1_valid_q & ~stall;
   assign s1_free = ~s1_valid_q | s2_adv;
   assign accept  = s1_free & gnt_found & ~rst;

   // Search starts one past the last winner and wraps at NUM_REQ (not at 2**ID_W).
   always_comb begin
      cand      = ptr_q;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = (cand == ID_W'(NUM_REQ - 1)) ? '0 : cand + ID_W'(1);
         if (!gnt_found && req_valid[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (accept) begin
         req_ready[gnt_idx] = 1'b1;
      end
   end

   always_comb begin
      s1_valid_d   = s1_valid_q;
      s1_id_d      = s1_id_q;
      s1_a_d       = s1_a_q;
      s1_b_d       = s1_b_q;
      s1_pc_d      = s1_pc_q;
      s1_op_d      = s1_op_q;
      resp_valid_d = resp_valid_q;
      resp_id_d    = resp_id_q;
      resp_c_d     = resp_c_q;
      resp_zero_d  = resp_zero_q;
      ptr_d        = ptr_q;

      if (accept) begin
         s1_valid_d = 1'b1;
         s1_id_d    = gnt_idx;
         s1_a_d     = a_arr[gnt_idx];
         s1_b_d     = b_arr[gnt_idx];
         s1_pc_d    = pc_arr[gnt_idx];
         s1_op_d    = op_arr[gnt_idx];
         ptr_d      = gnt_idx;
      end else if (s2_adv) begin
         s1_valid_d = 1'b0;
      end

      // A response leaving and a new one arriving on the same edge overlap without a bubble.
      if (s2_adv) begin
         resp_valid_d = 1'b1;
         resp_id_d    = s1_id_q;
         resp_c_d     = alu_C;
         resp_zero_d  = alu_zero;
      end else if (resp_ready) begin
         resp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q   <= 1'b0;
         s1_id_q      <= '0;
         s1_a_q       <= '0;
         s1_b_q       <= '0;
         s1_pc_q      <= '0;
         s1_op_q      <= '0;
         resp_valid_q <= 1'b0;
         resp_id_q    <= '0;
         resp_c_q     <= '0;
         resp_zero_q  <= 1'b0;
         ptr_q        <= ID_W'(NUM_REQ - 1);
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_id_q      <= s1_id_d;
         s1_a_q       <= s1_a_d;
         s1_b_q       <= s1_b_d;
         s1_pc_q      <= s1_pc_d;
         s1_op_q      <= s1_op_d;
         resp_valid_q <= resp_valid_d;
         resp_id_q    <= resp_id_d;
         resp_c_q     <= resp_c_d;
         resp_zero_q  <= resp_zero_d;
         ptr_q        <= ptr_d;
      end
   end

   assign alu_A      = s1_a_q;
   assign alu_B      = s1_b_q;
   assign alu_PC     = s1_pc_q;
   assign alu_op     = s1_op_q;
   assign resp_valid = resp_valid_q;
   assign resp_id    = resp_id_q;
   assign resp_c     = resp_c_q;
   assign resp_zero  = resp_zero_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb with three requesters, a behavioural ALU and an in-order response scoreboard.
module tb_alu_share_arb;
   localparam int N   = 3;
   localparam int IDW = 2;
   localparam logic [4:0] OP_ADD = 5'd1, OP_SUB = 5'd2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [N-1:0]    req_valid = '0;
   logic [N-1:0]    req_ready;
   logic [32*N-1:0] req_a = '0, req_b = '0, req_pc = '0;
   logic [5*N-1:0]  req_op = '0;
   logic [31:0]     alu_A, alu_B, alu_PC, alu_C;
   logic [4:0]      alu_op;
   logic            alu_zero;
   logic            resp_valid, resp_zero;
   logic            resp_ready = 1'b0;
   logic [IDW-1:0]  resp_id;
   logic [31:0]     resp_c;

   always #5 clk = ~clk;

   alu_share_arb #(.NUM_REQ(N), .ID_W(IDW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_pc(req_pc),
      .alu_A(alu_A), .alu_B(alu_B), .alu_PC(alu_PC), .alu_op(alu_op),
      .alu_C(alu_C), .alu_zero(alu_zero),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_id(resp_id), .resp_c(resp_c), .resp_zero(resp_zero)
   );

   // Opcodes: 1 add, 2 sub, 3 and, 4 or, 5 xor, 6 pc+b, anything else yields 0.
   function automatic logic [31:0] alu_f(input logic [4:0] op, input logic [31:0] a, b, pc);
      case (op)
         5'd1:    return a + b;
         5'd2:    return a - b;
         5'd3:    return a & b;
         5'd4:    return a | b;
         5'd5:    return a ^ b;
         5'd6:    return pc + b;
         default: return 32'd0;
      endcase
   endfunction

   always_comb begin
      alu_C    = alu_f(alu_op, alu_A, alu_B, alu_PC);
      alu_zero = (alu_C == 32'd0);
   end

   typedef struct { logic [31:0] a, b, pc; logic [4:0] op; } req_t;
   typedef struct { int id; req_t r; int acc; int vis; } item_t;

   req_t  pend [N];
   bit    pend_v [N];
   bit    en [N];
   item_t q [$];
   int    grants [$];
   int    mptr = N - 1;
   int    cyc = 0;
   int    rr_mode = 0;
   int    n_checks = 0, n_fail = 0;
   int    n_dut_resp = 0, n_exp_resp = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic req_t rand_req();
      req_t r;
      r.a  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 4));
      r.b  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 4));
      r.pc = $urandom;
      r.op = 5'($urandom_range(0, 7));
      return r;
   endfunction

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         if (!pend_v[i] && en[i]) begin
            pend[i]   = rand_req();
            pend_v[i] = 1'b1;
         end
         req_valid[i]       = pend_v[i];
         req_a[32*i +: 32]  = pend[i].a;
         req_b[32*i +: 32]  = pend[i].b;
         req_pc[32*i +: 32] = pend[i].pc;
         req_op[5*i +: 5]   = pend[i].op;
      end
      case (rr_mode)
         0:       resp_ready = 1'b1;
         1:       resp_ready = 1'($urandom_range(0, 1));
         default: resp_ready = 1'b0;
      endcase
   endtask

   // Model: queue of accepted, not yet delivered ops. An item becomes visible one edge after
   // acceptance, or on the edge its predecessor is handed over, whichever is later.
   task automatic check_cycle();
      bit exp_rv, free;
      int g, c;
      logic [N-1:0] exp_rdy;
      logic [31:0] res;
      item_t it;
      exp_rv = (q.size() > 0) && (q[0].vis <= cyc);
      check("resp_valid", resp_valid, exp_rv);
      if (exp_rv) begin
         res = alu_f(q[0].r.op, q[0].r.a, q[0].r.b, q[0].r.pc);
         check("resp_id", resp_id, q[0].id);
         check("resp_c", resp_c, res);
         check("resp_zero", resp_zero, res == 32'd0);
      end
      if (q.size() == 2 || (q.size() == 1 && !exp_rv)) begin
         it = q[q.size() - 1];
         check("alu_A", alu_A, it.r.a);
         check("alu_B", alu_B, it.r.b);
         check("alu_PC", alu_PC, it.r.pc);
         check("alu_op", alu_op, it.r.op);
      end
      free = !(q.size() == 2 && exp_rv && !resp_ready);
      g = -1;
      if (free) begin
         for (int k = 1; k <= N; k++) begin
            c = (mptr + k) % N;
            if (g < 0 && req_valid[c]) g = c;
         end
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      check("req_ready", req_ready, exp_rdy);
      if (resp_valid && resp_ready) n_dut_resp++;
      if (exp_rv && resp_ready) begin
         void'(q.pop_front());
         n_exp_resp++;
         if (q.size() > 0) q[0].vis = (q[0].acc + 1 > cyc + 1) ? q[0].acc + 1 : cyc + 1;
      end
      if (g >= 0) begin
         it.id  = g;
         it.r   = pend[g];
         it.acc = cyc + 1;
         it.vis = cyc + 2;
         q.push_back(it);
         pend_v[g] = 1'b0;
         mptr = g;
         grants.push_back(g);
      end
   endtask

   task automatic step();
      @(negedge clk);
      drive();
      #1;
      check_cycle();
   endtask

   task automatic do_reset(input int cycles, input string tag);
      @(negedge clk);
      rst = 1'b1;
      q.delete();
      mptr = N - 1;
      repeat (cycles) @(posedge clk);
      #1;
      check({tag, "_resp_valid"}, resp_valid, 0);
      check({tag, "_req_ready"}, req_ready, 0);
      check({tag, "_alu_op"}, alu_op, 0);
      check({tag, "_alu_A"}, alu_A, 0);
      check({tag, "_alu_B"}, alu_B, 0);
      check({tag, "_alu_PC"}, alu_PC, 0);
      check({tag, "_resp_id"}, resp_id, 0);
      check({tag, "_resp_c"}, resp_c, 0);
      check({tag, "_resp_zero"}, resp_zero, 0);
      @(negedge clk);
      rst = 1'b0;
      drive();
      #1;
      check_cycle();
   endtask

   int exp_alt [4] = '{0, 1, 0, 1};
   int exp_wrap [4] = '{0, 2, 0, 2};

   initial begin
      for (int i = 0; i < N; i++) begin
         pend_v[i] = 1'b0;
         en[i]     = 1'b0;
         pend[i]   = '{a: 0, b: 0, pc: 0, op: 0};
      end

      // Reset values, then a single add.
      do_reset(2, "rst");
      pend[0]   = '{a: 32'd5, b: 32'd7, pc: 32'd0, op: OP_ADD};
      pend_v[0] = 1'b1;
      step();
      step();
      check("t2_in_s1", resp_valid, 0);
      step();
      check("t2_lat_valid", resp_valid, 1);
      check("t2_id", resp_id, 0);
      check("t2_c", resp_c, 32'd12);
      check("t2_zero", resp_zero, 0);
      repeat (3) step();

      // Contention between 0 and 1, requester 1 starts with 3-3.
      en[0] = 1'b1; en[1] = 1'b1; en[2] = 1'b0;
      pend[1]   = '{a: 32'd3, b: 32'd3, pc: 32'd0, op: OP_SUB};
      pend_v[1] = 1'b1;
      pend_v[2] = 1'b0;
      grants.delete();
      do_reset(2, "t3rst");
      repeat (12) step();
      for (int i = 0; i < 4; i++)
         check($sformatf("t3_grant%0d", i), (i < grants.size()) ? grants[i] : -1, exp_alt[i]);

      // Backpressure with both stages full.
      rr_mode = 2;
      repeat (3) begin
         step();
         check("t4_bp_rdy", req_ready, 0);
         check("t4_bp_valid", resp_valid, 1);
      end
      rr_mode = 0;
      repeat (6) step();

      // Wrap: only requesters 2 and 0.
      en[0] = 1'b1; en[1] = 1'b0; en[2] = 1'b1;
      pend_v[1] = 1'b0;
      grants.delete();
      do_reset(2, "t5rst");
      repeat (10) step();
      for (int i = 0; i < 4; i++)
         check($sformatf("t5_grant%0d", i), (i < grants.size()) ? grants[i] : -1, exp_wrap[i]);

      // Reset with both stages occupied, then random traffic.
      en[0] = 1'b1; en[1] = 1'b1; en[2] = 1'b1;
      rr_mode = 2;
      repeat (4) step();
      check("t6_full", resp_valid, 1);
      do_reset(1, "t6mid");
      rr_mode = 1;
      repeat (400) step();
      en[0] = 1'b0; en[1] = 1'b0; en[2] = 1'b0;
      rr_mode = 0;
      repeat (12) step();
      check("resp_count", n_dut_resp, n_exp_resp);
      check("drained_valid", resp_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
